serial_magnitude_comparator: RTL and testbench
==============================================

Name: serial_magnitude_comparator

Overview:
Multi-cycle magnitude comparator for two WIDTH-bit operands. It processes DIGIT bits per clock, most significant digit first, and keeps the eq/gt/lt cascade in registers rather than in a chain of combinational stages. It supports signed (two's complement) and unsigned modes and can terminate early once the result is decided. Valid/ready handshakes on both the input and output sides let it sit between operand sources and result consumers in the comparator datapath.

Parameters:
WIDTH, 8, operand width in bits; must be a multiple of DIGIT, otherwise elaboration fails.
DIGIT, 2, bits compared per clock; DIGIT=WIDTH gives a single-step compare.
EARLY_EXIT, 1, 1 = finish as soon as the cascade is no longer equal; 0 = always run all WIDTH/DIGIT steps.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset; asynchronous assert, active-low
in_valid  in  1  operands and mode are valid
in_ready  out  1  block can accept operands (high only in IDLE)
x  in  WIDTH  operand A
y  in  WIDTH  operand B
is_signed  in  1  1 = two's complement compare, 0 = unsigned
out_valid  out  1  result is valid
out_ready  in  1  consumer accepts the result
eq  out  1  x == y
gt  out  1  x > y
lt  out  1  x < y
steps  out  $clog2(WIDTH/DIGIT)+1  number of digit steps used for the result

Behaviour:
- NDIG = WIDTH/DIGIT. Digit 0 is bits [WIDTH-1 : WIDTH-DIGIT].
- Reset (rst_n low, any state):
  - State goes to IDLE and any operation in progress is aborted with no result emitted.
  - out_valid=0, eq=0, gt=0, lt=0, steps=0.
  - in_ready=1 once in IDLE; in_valid is ignored while rst_n is low.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1: latch x, y and is_signed.
  - Initialise the cascade to ceq=1, cgt=0, clt=0 and the digit index to 0.
  - Go to COMPARE.
- COMPARE (in_ready=0); each edge processes one digit:
  - If ceq=1: ceq = (xd==yd), cgt = (xd>yd), clt = (xd<yd). If ceq=0, hold the cascade.
  - Signed mode: the MSB of digit 0 is inverted on both operands before comparing (offset-binary equivalence). All other bits compare unsigned.
  - Leave for DONE when either condition holds:
    - EARLY_EXIT=1 and the updated ceq=0, or
    - the digit just processed is NDIG-1.
  - On the transition to DONE, register eq/gt/lt from the cascade and set steps = digits processed (1..NDIG).
- DONE:
  - out_valid=1. eq/gt/lt/steps are stable until the handshake; exactly one of eq/gt/lt is 1.
  - On an edge with out_ready=1: out_valid goes to 0 and state goes to IDLE.
  - There is no same-cycle re-accept; in_ready rises the cycle after the handshake.
- After out_valid falls, eq/gt/lt/steps hold their last values.
- Latency: operands accepted at edge E0 and resolved at digit j (0-based) give out_valid=1 after edge E(j+1). Worst case is NDIG cycles.
- Throughput: at most one compare per NDIG+2 cycles.
- In COMPARE and DONE, changes on x, y, is_signed and in_valid have no effect.
- out_ready is ignored outside DONE.
- With DIGIT=WIDTH, steps is always 1.

Test Plan:
(All scenarios use WIDTH=8, DIGIT=2 unless noted.)
1. Unsigned early exit: x=0xFF, y=0x00 -> out_valid after 1 cycle, gt=1, eq=lt=0, steps=1. With EARLY_EXIT=0: out_valid after 4 cycles, gt=1, steps=4.
2. Equality: x=y=0x5A, unsigned -> out_valid after 4 cycles, eq=1, steps=4.
3. Signed vs unsigned: x=0x80, y=0x7F:
   - is_signed=1 -> lt=1, steps=1.
   - is_signed=0 -> gt=1, steps=1.
   - Also x=0xFE, y=0xFF signed -> lt=1, steps=4.
4. Backpressure: x=0x12, y=0x13 with out_ready low for 3 cycles in DONE -> lt=1 and steps=4 stay stable, in_ready=0, a new in_valid pulse is ignored. The handshake then gives in_ready=1 one cycle later.
5. Reset mid-operation: assert rst_n low in the 2nd COMPARE cycle -> out_valid=0 and eq=gt=lt=0 immediately. After release, in_ready=1, and the next transaction x=0x03, y=0x01 gives gt=1, steps=4.
6. Exhaustive sweep: all 65536 x/y pairs in both modes, with out_ready tied high. Check eq/gt/lt against behavioural ==, > and < (using $signed in signed mode). Check steps equals the index of the first differing digit +1 (4 when equal). Run with DIGIT=1, 2, 4 and 8.

Source files
------------

// File: rtl/serial_magnitude_comparator_if.sv
// Operand/result handshake bundle for the serial magnitude comparator.
// The master side supplies operands and consumes results; the slave side is the comparator.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
);
    localparam int SW = $clog2(WIDTH / DIGIT) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic             eq;
    logic             gt;
    logic             lt;
    logic [SW-1:0]    steps;

    modport master (
        output in_valid, x, y, is_signed, out_ready,
        input  in_ready, out_valid, eq, gt, lt, steps
    );

    modport slave (
        input  in_valid, x, y, is_signed, out_ready,
        output in_ready, out_valid, eq, gt, lt, steps
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks DIGIT bits per clock, MS digit first,
// keeping the eq/gt/lt cascade in registers, with optional early termination.
module serial_magnitude_comparator #(
    parameter int WIDTH      = 8,
    parameter int DIGIT      = 2,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_magnitude_comparator_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int SW   = $clog2(NDIG) + 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
    localparam logic [SW-1:0]    LAST_IDX = SW'(NDIG - 1);

    if (WIDTH % DIGIT != 0) begin : g_width_check
        $error("serial_magnitude_comparator: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic             ceq_q, ceq_d;
    logic             cgt_q, cgt_d;
    logic             clt_q, clt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic [SW-1:0]    steps_q, steps_d;

    logic [DIGIT-1:0] xd, yd;
    logic             step_eq, step_gt, step_lt;
    logic             finish;

    // State, operand shift registers, cascade and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            ceq_q   <= 1'b0;
            cgt_q   <= 1'b0;
            clt_q   <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            ceq_q   <= ceq_d;
            cgt_q   <= cgt_d;
            clt_q   <= clt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            steps_q <= steps_d;
        end
    end

    // Next-state, digit cascade update and result capture
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        ceq_d   = ceq_q;
        cgt_d   = cgt_q;
        clt_d   = clt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        steps_d = steps_q;

        // Operands are shifted left each step, so the current digit is always on top.
        xd = x_q[WIDTH-1 -: DIGIT];
        yd = y_q[WIDTH-1 -: DIGIT];

        // Once the cascade is decided it is held.
        step_eq = ceq_q ? (xd == yd) : 1'b0;
        step_gt = ceq_q ? (xd > yd)  : cgt_q;
        step_lt = ceq_q ? (xd < yd)  : clt_q;
        finish  = (EARLY_EXIT && !step_eq) || (cnt_q == LAST_IDX);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Signed compare: flipping the sign bit once at latch time makes
                    // two's complement order match unsigned order for every digit.
                    x_d     = bus.x ^ (bus.is_signed ? MSB_MASK : '0);
                    y_d     = bus.y ^ (bus.is_signed ? MSB_MASK : '0);
                    cnt_d   = '0;
                    ceq_d   = 1'b1;
                    cgt_d   = 1'b0;
                    clt_d   = 1'b0;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                ceq_d = step_eq;
                cgt_d = step_gt;
                clt_d = step_lt;
                x_d   = x_q << DIGIT;
                y_d   = y_q << DIGIT;
                cnt_d = cnt_q + 1'b1;
                if (finish) begin
                    eq_d    = step_eq;
                    gt_d    = step_gt;
                    lt_d    = step_lt;
                    steps_d = cnt_q + 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.eq        = eq_q;
    assign bus.gt        = gt_q;
    assign bus.lt        = lt_q;
    assign bus.steps     = steps_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed self-checking bench for serial_magnitude_comparator across several
// DIGIT / EARLY_EXIT configurations at WIDTH=8.
module tb_serial_magnitude_comparator;
    localparam int NCFG = 5;

    function automatic int dig_of(input int k);
        case (k)
            2:       return 1;
            3:       return 4;
            4:       return 8;
            default: return 2;
        endcase
    endfunction

    function automatic bit ee_of(input int k);
        return (k != 1);
    endfunction

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] x_s, y_s;
    logic       sgn_s;
    logic       out_ready_s;
    logic       in_valid_a [NCFG];
    logic       ov_a [NCFG];
    logic       ir_a [NCFG];
    logic       eq_a [NCFG];
    logic       gt_a [NCFG];
    logic       lt_a [NCFG];
    logic [3:0] steps_a [NCFG];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NCFG; k++) begin : g_dut
        serial_magnitude_comparator_if #(.WIDTH(8), .DIGIT(dig_of(k))) bus ();
        serial_magnitude_comparator #(
            .WIDTH(8),
            .DIGIT(dig_of(k)),
            .EARLY_EXIT(ee_of(k))
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .bus(bus)
        );
        assign bus.in_valid  = in_valid_a[k];
        assign bus.x         = x_s;
        assign bus.y         = y_s;
        assign bus.is_signed = sgn_s;
        assign bus.out_ready = out_ready_s;
        assign ov_a[k]       = bus.out_valid;
        assign ir_a[k]       = bus.in_ready;
        assign eq_a[k]       = bus.eq;
        assign gt_a[k]       = bus.gt;
        assign lt_a[k]       = bus.lt;
        assign steps_a[k]    = 4'(bus.steps);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one cycle to config k; returns just after the accepting edge.
    task automatic start(input int k, input logic [7:0] xv, input logic [7:0] yv, input logic sv);
        check($sformatf("c%0d in_ready before start", k), ir_a[k], 1);
        x_s           = xv;
        y_s           = yv;
        sgn_s         = sv;
        in_valid_a[k] = 1'b1;
        tick();
        in_valid_a[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, output int lat);
        lat = 0;
        while (!ov_a[k] && lat < 20) begin
            tick();
            lat++;
        end
        check($sformatf("c%0d out_valid within budget", k), ov_a[k], 1);
    endtask

    // Behavioural reference: relational operators plus first differing digit.
    task automatic model(input int k, input logic [7:0] xv, input logic [7:0] yv, input logic sv,
                         output logic e, output logic g, output logic l, output int st);
        int dig;
        int nd;
        logic [7:0] diff;
        dig  = dig_of(k);
        nd   = 8 / dig;
        e    = (xv == yv);
        g    = sv ? ($signed(xv) > $signed(yv)) : (xv > yv);
        l    = sv ? ($signed(xv) < $signed(yv)) : (xv < yv);
        st   = nd;
        diff = xv ^ yv;
        if (ee_of(k) && diff != 8'h00) begin
            for (int p = 7; p >= 0; p--) begin
                if (diff[p]) begin
                    st = (7 - p) / dig + 1;
                    break;
                end
            end
        end
    endtask

    task automatic full_op(input int k, input logic [7:0] xv, input logic [7:0] yv, input logic sv);
        int   lat;
        int   st;
        logic e, g, l;
        string tg;
        tg = $sformatf("c%0d %02h/%02h s%0d", k, xv, yv, sv);
        model(k, xv, yv, sv, e, g, l, st);
        start(k, xv, yv, sv);
        wait_done(k, lat);
        check({tg, " eq"}, eq_a[k], e);
        check({tg, " gt"}, gt_a[k], g);
        check({tg, " lt"}, lt_a[k], l);
        check({tg, " steps"}, steps_a[k], st);
        check({tg, " latency"}, lat, st);
        tick();
        check({tg, " out_valid after handshake"}, ov_a[k], 0);
        check({tg, " in_ready after handshake"}, ir_a[k], 1);
    endtask

    logic [7:0] vals [10] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF, 8'h5A, 8'hA5, 8'h3C};

    initial begin
        int lat;
        rst_n       = 1'b0;
        x_s         = '0;
        y_s         = '0;
        sgn_s       = 1'b0;
        out_ready_s = 1'b1;
        for (int k = 0; k < NCFG; k++) in_valid_a[k] = 1'b0;
        in_valid_a[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", ov_a[0], 0);
        check("reset in_ready", ir_a[0], 1);
        check("reset eq", eq_a[0], 0);
        check("reset gt", gt_a[0], 0);
        check("reset lt", lt_a[0], 0);
        check("reset steps", steps_a[0], 0);
        in_valid_a[0] = 1'b0;
        rst_n = 1'b1;
        tick();

        // Early exit vs full run, equality, signed/unsigned ordering
        full_op(0, 8'hFF, 8'h00, 1'b0);
        full_op(1, 8'hFF, 8'h00, 1'b0);
        full_op(0, 8'h5A, 8'h5A, 1'b0);
        full_op(0, 8'h80, 8'h7F, 1'b1);
        full_op(0, 8'h80, 8'h7F, 1'b0);
        full_op(0, 8'hFE, 8'hFF, 1'b1);

        // Backpressure: result held, in_ready low, extra in_valid ignored
        out_ready_s = 1'b0;
        start(0, 8'h12, 8'h13, 1'b0);
        wait_done(0, lat);
        check("bp latency", lat, 4);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp%0d out_valid", c), ov_a[0], 1);
            check($sformatf("bp%0d lt", c), lt_a[0], 1);
            check($sformatf("bp%0d gt", c), gt_a[0], 0);
            check($sformatf("bp%0d steps", c), steps_a[0], 4);
            check($sformatf("bp%0d in_ready", c), ir_a[0], 0);
            if (c == 1) begin
                x_s           = 8'hFF;
                y_s           = 8'h00;
                in_valid_a[0] = 1'b1;
            end
            tick();
            in_valid_a[0] = 1'b0;
        end
        out_ready_s = 1'b1;
        tick();
        check("bp out_valid after handshake", ov_a[0], 0);
        check("bp in_ready after handshake", ir_a[0], 1);
        check("bp lt held", lt_a[0], 1);
        check("bp steps held", steps_a[0], 4);
        tick();
        check("bp ignored pulse out_valid", ov_a[0], 0);
        check("bp ignored pulse in_ready", ir_a[0], 1);

        // Reset in the second COMPARE cycle
        start(0, 8'h12, 8'h13, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("mid-reset out_valid", ov_a[0], 0);
        check("mid-reset eq", eq_a[0], 0);
        check("mid-reset gt", gt_a[0], 0);
        check("mid-reset lt", lt_a[0], 0);
        check("mid-reset steps", steps_a[0], 0);
        check("mid-reset in_ready", ir_a[0], 1);
        #2;
        rst_n = 1'b1;
        tick();
        check("post-reset in_ready", ir_a[0], 1);
        check("post-reset out_valid", ov_a[0], 0);
        full_op(0, 8'h03, 8'h01, 1'b0);

        // Boundary-value sweep on every configuration, both modes
        for (int k = 0; k < NCFG; k++)
            for (int i = 0; i < 10; i++)
                for (int j = 0; j < 10; j++)
                    for (int s = 0; s < 2; s++)
                        full_op(k, vals[i], vals[j], s[0]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
